bch15_bm_block: RTL and testbench

// - Key-equation solver for the binary BCH(15,7) double-error-correcting decoder over GF(2^4).
// - Takes syndromes S1..S3 from the syndrome stage and returns the normalized error-locator

---
 rtl/bch15_bm_block.sv | 78 +++++++
 tb/tb_bch15_bm_block.sv | 103 ++++++++++
 2 files changed

// File: rtl/bch15_bm_block.sv
// Closed-form t=2 Berlekamp-Massey key-equation solver for BCH(15,7) over GF(16), p(x)=x^4+x+1.
// Registers Lambda(x) = 1 + lambda1*x + lambda2*x^2 one cycle after the syndromes are sampled.
module bch15_bm_block (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] S1,
   input  logic [3:0] S2,
   input  logic [3:0] S3,
   output logic [3:0] lambda1,
   output logic [3:0] lambda2
);

   function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
      logic [6:0] p;
      p = '0;
      for (int i = 0; i < 4; i++)
         if (b[i]) p = p ^ ({3'b000, a} << i);
      // Fold x^6..x^4 back in with x^4 = x + 1
      for (int k = 6; k >= 4; k--)
         if (p[k]) p = p ^ (7'b0010011 << (k - 4));
      return p[3:0];
   endfunction

   function automatic logic [3:0] gf_inv(input logic [3:0] a);
      logic [3:0] r;
      case (a)
         4'h1:    r = 4'h1;
         4'h2:    r = 4'h9;
         4'h3:    r = 4'hE;
         4'h4:    r = 4'hD;
         4'h5:    r = 4'hB;
         4'h6:    r = 4'h7;
         4'h7:    r = 4'h6;
         4'h8:    r = 4'hF;
         4'h9:    r = 4'h2;
         4'hA:    r = 4'hC;
         4'hB:    r = 4'h5;
         4'hC:    r = 4'hA;
         4'hD:    r = 4'h4;
         4'hE:    r = 4'h3;
         4'hF:    r = 4'h8;
         default: r = 4'h0;
      endcase
      return r;
   endfunction

   logic [3:0] w_delta;
   logic [3:0] w_lambda1;
   logic [3:0] w_lambda2;
   logic [3:0] r_lambda1;
   logic [3:0] r_lambda2;

   // S2 is taken as given, so inconsistent syndromes still flow through unchanged
   assign w_delta = S3 ^ gf_mul(S1, S2);

   always_comb begin
      w_lambda1 = 4'h0;
      w_lambda2 = 4'h0;
      if (S1 != 4'h0) begin
         w_lambda1 = S1;
         w_lambda2 = gf_mul(w_delta, gf_inv(S1));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_lambda1 <= 4'h0;
         r_lambda2 <= 4'h0;
      end else begin
         r_lambda1 <= w_lambda1;
         r_lambda2 <= w_lambda2;
      end
   end

   assign lambda1 = r_lambda1;
   assign lambda2 = r_lambda2;

endmodule

// File: tb/tb_bch15_bm_block.sv
// Directed bench for bch15_bm_block: table of hand-computed GF(16) vectors plus reset/streaming sequences.
module tb_bch15_bm_block;

   logic       clk;
   logic       rst;
   logic [3:0] S1, S2, S3;
   logic [3:0] lambda1, lambda2;

   int n_checks = 0;
   int n_fail   = 0;

   bch15_bm_block dut (
      .clk     (clk),
      .rst     (rst),
      .S1      (S1),
      .S2      (S2),
      .S3      (S3),
      .lambda1 (lambda1),
      .lambda2 (lambda2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] s1, s2, s3;
      logic [3:0] e1, e2;
   } vec_t;

   vec_t tbl [8];

   task automatic check(input string name, input logic [3:0] e1, input logic [3:0] e2);
      n_checks++;
      if (lambda1 !== e1 || lambda2 !== e2) begin
         n_fail++;
         $display("FAIL %s: got lambda1=%b lambda2=%b, expected lambda1=%b lambda2=%b",
                  name, lambda1, lambda2, e1, e2);
      end
   endtask

   // Drive on the falling edge, check on the falling edge after the next rising edge
   task automatic apply(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
      @(negedge clk);
      S1 = a; S2 = b; S3 = c;
      @(negedge clk);
   endtask

   initial begin
      // alpha^k: a4=0011 a8=0101 a5=0110 a7=1011 a14=1001 a1=0010 a9=1010 a3=1000 a6=1100
      tbl[0] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0};  // no error
      tbl[1] = '{4'h3, 4'h5, 4'h6, 4'h3, 4'h7};  // x^7+x^3
      tbl[2] = '{4'hB, 4'h9, 4'h2, 4'hB, 4'h3};
      tbl[3] = '{4'hA, 4'h9, 4'h2, 4'hA, 4'h2};  // S2 inconsistent, used as given
      tbl[4] = '{4'hB, 4'hB, 4'h2, 4'hB, 4'h1};
      tbl[5] = '{4'h8, 4'hC, 4'hA, 4'h8, 4'h0};  // single error x^3: delta=0
      tbl[6] = '{4'h0, 4'h0, 4'h6, 4'h0, 4'h0};  // S1=0, S3!=0
      tbl[7] = '{4'h1, 4'h1, 4'h0, 4'h1, 4'h1};  // delta=1, inv(1)=1

      rst = 1'b1; S1 = 4'hF; S2 = 4'hF; S3 = 4'hF;
      @(negedge clk);
      @(negedge clk);
      check("reset", 4'h0, 4'h0);
      @(negedge clk);
      check("reset_holds_ignores_inputs", 4'h0, 4'h0);
      rst = 1'b0;

      for (int i = 0; i < 8; i++) begin
         apply(tbl[i].s1, tbl[i].s2, tbl[i].s3);
         check($sformatf("vec%0d", i), tbl[i].e1, tbl[i].e2);
      end

      // Back-to-back: each result must appear exactly one edge after its input
      @(negedge clk);
      S1 = tbl[1].s1; S2 = tbl[1].s2; S3 = tbl[1].s3;
      for (int i = 2; i < 6; i++) begin
         @(negedge clk);
         check($sformatf("b2b_%0d", i - 1), tbl[i-1].e1, tbl[i-1].e2);
         S1 = tbl[i].s1; S2 = tbl[i].s2; S3 = tbl[i].s3;
      end
      @(negedge clk);
      check("b2b_5", tbl[5].e1, tbl[5].e2);

      // Mid-stream reset overrides a nonzero result computed on the same edge
      S1 = tbl[2].s1; S2 = tbl[2].s2; S3 = tbl[2].s3;
      @(negedge clk);
      check("pre_reset", tbl[2].e1, tbl[2].e2);
      rst = 1'b1;
      S1 = tbl[1].s1; S2 = tbl[1].s2; S3 = tbl[1].s3;
      @(negedge clk);
      check("mid_reset", 4'h0, 4'h0);
      rst = 1'b0;
      S1 = tbl[4].s1; S2 = tbl[4].s2; S3 = tbl[4].s3;
      @(negedge clk);
      check("post_reset", tbl[4].e1, tbl[4].e2);
      S1 = 4'h0; S2 = 4'h0; S3 = 4'h6;
      @(negedge clk);
      check("s1_zero_s3_nonzero", 4'h0, 4'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
